// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/stall controller: sequences the IF/ID, ID/EX, EX/MEM and MEM/WB
// register enables and flushes. Optional perf counters are enabled by `define HAZ_PERF_EN.
module pipe_hazard_ctrl #(
   parameter int REG_W  = 5,
   parameter int MD_LAT = 4,
   parameter int CNT_W  = 3
) (
   input  logic             clk,
   input  logic             Rst,
   input  logic             ext_hold,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_md_req,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_mem_read,
   input  logic             branch_taken,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             ifid_flush,
   output logic             idex_we,
   output logic             idex_flush,
   output logic             exmem_we,
   output logic             memwb_we,
   output logic             md_go,
   output logic             md_busy,
   output logic [31:0]      stall_cycles,
   output logic [31:0]      flush_count
);

   typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} state_t;

   // First MD_BUSY cycle follows the issue stall, so the count starts at MD_LAT-2.
   localparam logic [CNT_W-1:0] MD_INIT = CNT_W'(MD_LAT - 2);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] md_cnt, md_cnt_nxt;
   logic             lu;

   assign lu = ex_mem_read && (ex_rd != '0) &&
               ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

   assign md_busy = (state == MD_BUSY);

   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         state  <= RUN;
         md_cnt <= '0;
      end else begin
         state  <= state_nxt;
         md_cnt <= md_cnt_nxt;
      end
   end

   always_comb begin
      pc_we      = 1'b1;
      ifid_we    = 1'b1;
      ifid_flush = 1'b0;
      idex_we    = 1'b1;
      idex_flush = 1'b0;
      exmem_we   = 1'b1;
      memwb_we   = 1'b1;
      md_go      = 1'b0;
      state_nxt  = state;
      md_cnt_nxt = md_cnt;

      if (ext_hold) begin
         pc_we    = 1'b0;
         ifid_we  = 1'b0;
         idex_we  = 1'b0;
         exmem_we = 1'b0;
         memwb_we = 1'b0;
      end else if (branch_taken) begin
         // A taken branch also abandons any mul/div still in flight.
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         state_nxt  = RUN;
         md_cnt_nxt = '0;
      end else if (state == MD_BUSY) begin
         if (md_cnt != '0) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
            md_cnt_nxt = md_cnt - 1'b1;
         end else begin
            md_go     = 1'b1;
            state_nxt = RUN;
         end
      end else if (lu) begin
         pc_we      = 1'b0;
         ifid_we    = 1'b0;
         idex_flush = 1'b1;
      end else if (id_md_req) begin
         pc_we      = 1'b0;
         ifid_we    = 1'b0;
         idex_flush = 1'b1;
         state_nxt  = MD_BUSY;
         md_cnt_nxt = MD_INIT;
      end
   end

`ifdef HAZ_PERF_EN
   // Front end frozen without an external hold is exactly a stall cycle.
   logic stall_inc;
   assign stall_inc = !ext_hold && !pc_we;

   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (stall_inc)  stall_cycles <= stall_cycles + 32'd1;
         if (ifid_flush) flush_count  <= flush_count + 32'd1;
      end
   end
`else
   assign stall_cycles = 32'b0;
   assign flush_count  = 32'b0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, multi-cycle mul/div sequences,
// and randomized traffic checked against a rule-level reference model.
module tb_pipe_hazard_ctrl;

   localparam int REG_W  = 5;
   localparam int MD_LAT = 4;
   localparam int CNT_W  = 3;

   typedef struct {
      logic             hold, br, load, use_rs, use_rt, md;
      logic [REG_W-1:0] ex_rd, rs, rt;
   } in_t;

   typedef struct {
      in_t        in;
      logic [8:0] exp;
   } vec_t;

   // Output vector order: pc, ifid_we, ifid_fl, idex_we, idex_fl, exmem, memwb, go, busy
   localparam logic [8:0] O_RUN   = 9'b110101100;
   localparam logic [8:0] O_STALL = 9'b000111100;
   localparam logic [8:0] O_BR    = 9'b111111100;
   localparam logic [8:0] O_HOLD  = 9'b000000000;
   localparam logic [8:0] O_MDST  = 9'b000111101;
   localparam logic [8:0] O_GO    = 9'b110101111;
   localparam logic [8:0] O_HOLDB = 9'b000000001;
   localparam logic [8:0] O_BRB   = 9'b111111101;

   logic clk = 1'b0;
   logic Rst;
   logic ext_hold, id_use_rs, id_use_rt, id_md_req, ex_mem_read, branch_taken;
   logic [REG_W-1:0] id_rs, id_rt, ex_rd;
   logic pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we, md_go, md_busy;
   logic [31:0] stall_cycles, flush_count;

   int total = 0;
   int bad   = 0;

   // Reference model state: mul/div in flight and stall cycles still owed before go.
   bit          m_busy;
   int          m_owed;
   logic [31:0] m_stall, m_flush;

   pipe_hazard_ctrl #(.REG_W(REG_W), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .Rst(Rst), .ext_hold(ext_hold),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_md_req(id_md_req), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
      .branch_taken(branch_taken),
      .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
      .idex_we(idex_we), .idex_flush(idex_flush), .exmem_we(exmem_we),
      .memwb_we(memwb_we), .md_go(md_go), .md_busy(md_busy),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   function automatic in_t mk(input logic hold, br, load, input int rd, rs, rt,
                              input logic urs, urt, md);
      in_t v;
      v.hold = hold; v.br = br; v.load = load;
      v.ex_rd = REG_W'(rd); v.rs = REG_W'(rs); v.rt = REG_W'(rt);
      v.use_rs = urs; v.use_rt = urt; v.md = md;
      return v;
   endfunction

   function automatic logic [8:0] outs();
      return {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we, md_go, md_busy};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic chk_counters(input string name);
`ifdef HAZ_PERF_EN
      chk({name, ".stall_cycles"}, stall_cycles, m_stall);
      chk({name, ".flush_count"}, flush_count, m_flush);
`else
      chk({name, ".stall_cycles"}, stall_cycles, 32'd0);
      chk({name, ".flush_count"}, flush_count, 32'd0);
`endif
   endtask

   task automatic model_reset();
      m_busy = 0; m_owed = 0; m_stall = '0; m_flush = '0;
   endtask

   // Applies the per-cycle priority rules; returns expected outputs and advances the model.
   task automatic model_cycle(input in_t v, output logic [8:0] e);
      bit pc, fwe, ffl, iwe, ifl, em, mw, go, haz;
      pc = 1; fwe = 1; ffl = 0; iwe = 1; ifl = 0; em = 1; mw = 1; go = 0;
      haz = v.load && (v.ex_rd != 0) &&
            ((v.use_rs && v.rs == v.ex_rd) || (v.use_rt && v.rt == v.ex_rd));
      e = 9'b0;
      e[0] = m_busy;
      if (v.hold) begin
         pc = 0; fwe = 0; iwe = 0; em = 0; mw = 0;
      end else if (v.br) begin
         ffl = 1; ifl = 1; m_flush += 1; m_busy = 0; m_owed = 0;
      end else if (m_busy) begin
         if (m_owed > 0) begin
            pc = 0; fwe = 0; ifl = 1; m_owed -= 1; m_stall += 1;
         end else begin
            go = 1; m_busy = 0;
         end
      end else if (haz) begin
         pc = 0; fwe = 0; ifl = 1; m_stall += 1;
      end else if (v.md) begin
         pc = 0; fwe = 0; ifl = 1; m_stall += 1;
         m_busy = 1; m_owed = MD_LAT - 2;
      end
      e[8:1] = {pc, fwe, ffl, iwe, ifl, em, mw, go};
   endtask

   // Called just after a rising edge; checks at the falling edge, returns just after the next rising edge.
   task automatic step(input in_t v, input bit use_exp, input logic [8:0] exp_v, input string name);
      logic [8:0] m_e;
      ext_hold = v.hold; branch_taken = v.br; ex_mem_read = v.load; ex_rd = v.ex_rd;
      id_rs = v.rs; id_rt = v.rt; id_use_rs = v.use_rs; id_use_rt = v.use_rt; id_md_req = v.md;
      @(negedge clk);
      chk_counters(name);
      model_cycle(v, m_e);
      chk({name, ".outs"}, {23'd0, outs()}, {23'd0, use_exp ? exp_v : m_e});
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      Rst = 1'b1;
      #2;
      model_reset();
      chk("reset.outs", {23'd0, outs()}, {23'd0, O_RUN});
      chk("reset.stall_cycles", stall_cycles, 32'd0);
      chk("reset.flush_count", flush_count, 32'd0);
      @(posedge clk);
      #1;
      Rst = 1'b0;
   endtask

   vec_t tbl[12];
   in_t  z;

   initial begin
      z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0), O_RUN};
      tbl[1]  = '{mk(0, 0, 1, 5, 5, 0, 1, 0, 0), O_STALL};
      tbl[2]  = '{mk(0, 0, 0, 5, 5, 0, 1, 0, 0), O_RUN};
      tbl[3]  = '{mk(0, 0, 1, 0, 0, 0, 1, 0, 0), O_RUN};
      tbl[4]  = '{mk(0, 0, 1, 7, 1, 7, 1, 1, 0), O_STALL};
      tbl[5]  = '{mk(0, 0, 1, 5, 5, 5, 0, 0, 0), O_RUN};
      tbl[6]  = '{mk(0, 0, 1, 9, 9, 3, 0, 1, 0), O_RUN};
      tbl[7]  = '{mk(0, 1, 1, 5, 5, 0, 1, 0, 0), O_BR};
      tbl[8]  = '{mk(1, 0, 1, 5, 5, 0, 1, 0, 0), O_HOLD};
      tbl[9]  = '{mk(1, 1, 0, 0, 0, 0, 0, 0, 0), O_HOLD};
      tbl[10] = '{mk(0, 0, 1, 3, 0, 3, 0, 1, 1), O_STALL};
      tbl[11] = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 1), O_HOLD};

      Rst = 1'b1;
      ext_hold = 0; branch_taken = 0; ex_mem_read = 0; ex_rd = '0;
      id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0; id_md_req = 0;
      @(posedge clk);
      #1;
      do_reset();

      for (int i = 0; i < 12; i++)
         step(tbl[i].in, 1, tbl[i].exp, $sformatf("vec%0d", i));
      step(z, 1, O_RUN, "vec_after");

      // Mul/div issue and completion.
      do_reset();
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 1, O_STALL, "md.issue");
      step(z, 1, O_MDST, "md.busy1");
      step(z, 1, O_MDST, "md.busy2");
      step(z, 1, O_GO,   "md.go");
      step(z, 1, O_RUN,  "md.done");
`ifdef HAZ_PERF_EN
      chk("md.stall_total", stall_cycles, 32'd3);
`else
      chk("md.stall_total", stall_cycles, 32'd0);
`endif

      // Hold freezes MD_BUSY; then a branch aborts it.
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 1, O_STALL, "abort.issue");
      step(z, 1, O_MDST, "abort.busy1");
      step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), 1, O_HOLDB, "abort.hold1");
      step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), 1, O_HOLDB, "abort.hold2");
      step(z, 1, O_MDST, "abort.busy2");
      step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0), 1, O_BRB, "abort.branch");
      for (int i = 0; i < 4; i++) step(z, 1, O_RUN, $sformatf("abort.idle%0d", i));

      // Hold stretches completion by the held cycles.
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 1, O_STALL, "hold.issue");
      step(z, 1, O_MDST, "hold.busy1");
      step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), 1, O_HOLDB, "hold.h1");
      step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), 1, O_HOLDB, "hold.h2");
      step(z, 1, O_MDST, "hold.busy2");
      step(z, 1, O_GO, "hold.go");

      // Asynchronous reset in the middle of MD_BUSY.
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 1, O_STALL, "rst.issue");
      step(z, 1, O_MDST, "rst.busy1");
      Rst = 1'b1;
      #2;
      model_reset();
      chk("rst.async_outs", {23'd0, outs()}, {23'd0, O_RUN});
      chk("rst.async_stall", stall_cycles, 32'd0);
      #1;
      Rst = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) step(z, 1, O_RUN, $sformatf("rst.idle%0d", i));

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         in_t r;
         r = mk($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom_range(0, 3) == 0);
         step(r, 0, 9'd0, $sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
